// File: rtl/mips_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_pkg : shared types and constants for the MIPS pipeline stages        |
// | Rev 1.0  : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam word_t PC_STEP   = 32'd4;

  // The ROM is word-addressed, so its index is the byte PC shifted right by two
  function automatic word_t word_index(input word_t byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// +--------------------------------------------------------------------------+
// | fetch_stage_if : control, instruction-ROM and IF/ID bundle of the fetch   |
// | stage. The master modport is the fetch stage, the slave its environment.  |
// | Rev 1.0  : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

interface fetch_stage_if;
  import mips_pkg::*;

  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t imem_addr;
  word_t imem_rdata;
  word_t pc;
  word_t if_id_instr;
  word_t if_id_pc4;
  logic  if_id_valid;
  word_t fetch_count;
  logic  fetch_fault;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
           fetch_count, fetch_fault
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
           fetch_count, fetch_fault
  );

endinterface

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// +--------------------------------------------------------------------------+
// | if_id_reg : IF/ID pipeline register with load / hold / flush controls.    |
// | Priority is reset > flush > load > hold. Flush keeps pc4.                 |
// | Rev 1.0  : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module if_id_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  flush,
  input  word_t instr_d,
  input  word_t pc4_d,
  input  logic  valid_d,
  output word_t instr,
  output word_t pc4,
  output logic  valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------------+
// | fetch_stage : PC, next-PC selection, fetch counter and IF/ID capture.     |
// | Optional macro IMEM_RANGE_CHECK_EN enables out-of-range fetch detection.  |
// | Rev 1.0  : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import mips_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    IMEM_WORDS = 64
)(
  input  logic           clk,
  input  logic           reset,
  fetch_stage_if.master  bus
);

`ifdef IMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  word_t pc_q;
  word_t count_q;
  word_t pc_plus4;
  logic  sequential;
  logic  out_of_range;

  assign pc_plus4     = pc_q + PC_STEP;
  assign sequential   = !bus.redirect && !bus.stall;
  assign out_of_range = RANGE_CHECK && (word_index(pc_q) >= 32'(IMEM_WORDS));

  assign bus.imem_addr   = word_index(pc_q);
  assign bus.pc          = pc_q;
  assign bus.fetch_count = count_q;

  // Redirect beats stall; the target's low two bits are dropped silently
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else if (bus.redirect) begin
      pc_q <= bus.redirect_pc & ~32'h3;
    end else if (!bus.stall) begin
      pc_q <= pc_plus4;
      if (!out_of_range) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

`ifdef IMEM_RANGE_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (sequential && out_of_range) begin
      fault_q <= 1'b1;
    end
  end

  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (sequential),
    .flush   (bus.redirect),
    .instr_d (out_of_range ? NOP_INSTR : bus.imem_rdata),
    .pc4_d   (pc_plus4),
    .valid_d (!out_of_range),
    .instr   (bus.if_id_instr),
    .pc4     (bus.if_id_pc4),
    .valid   (bus.if_id_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : directed scoreboard bench for fetch_stage.               |
// | Rev 1.0  : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;
  import mips_pkg::*;

  typedef struct packed {
    int unsigned cycle;
    word_t       pc;
    word_t       instr;
    word_t       pc4;
    logic        valid;
    word_t       cnt;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  exp_t        sb[$];

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic word_t rom_word(input word_t idx);
    case (idx)
      32'd0:   return 32'h11;
      32'd1:   return 32'h22;
      32'd2:   return 32'h33;
      32'd3:   return 32'h44;
      default: return 32'h1000 + idx;
    endcase
  endfunction

  assign bus.imem_rdata = (bus.imem_addr < 32'd64) ? rom_word(bus.imem_addr) : 32'hDEAD_BEEF;

  // Drive one cycle of inputs; the expected outputs after the next edge go on the scoreboard
  task automatic step(input logic rst, input logic s, input logic r, input word_t rpc,
                      input word_t e_pc, input word_t e_instr, input word_t e_pc4,
                      input logic e_valid, input word_t e_cnt, input logic e_fault);
    exp_t e;
    @(negedge clk);
    reset           = rst;
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    e.cycle = cyc + 1;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.pc4   = e_pc4;
    e.valid = e_valid;
    e.cnt   = e_cnt;
    e.fault = e_fault;
    sb.push_back(e);
  endtask

  // Monitor: compare every entry due this cycle against the live outputs
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cycle <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (e.cycle == cyc && bus.pc == e.pc && bus.if_id_instr == e.instr &&
            bus.if_id_pc4 == e.pc4 && bus.if_id_valid == e.valid &&
            bus.fetch_count == e.cnt && bus.fetch_fault == e.fault) begin
          passes++;
        end else begin
          $display("FAIL cycle%0d: got pc=%h instr=%h pc4=%h valid=%b cnt=%0d fault=%b, expected pc=%h instr=%h pc4=%h valid=%b cnt=%0d fault=%b",
                   e.cycle, bus.pc, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid,
                   bus.fetch_count, bus.fetch_fault, e.pc, e.instr, e.pc4, e.valid,
                   e.cnt, e.fault);
        end
      end
    end
  end

  initial begin
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // reset, then sequential fetch of ROM[0..2]
    step(1, 0, 0, 0,     32'h0,  32'h0,  32'h0,  0, 0, 0);
    step(0, 0, 0, 0,     32'h4,  32'h11, 32'h4,  1, 1, 0);
    step(0, 0, 0, 0,     32'h8,  32'h22, 32'h8,  1, 2, 0);
    // stall three cycles at pc=8
    step(0, 1, 0, 0,     32'h8,  32'h22, 32'h8,  1, 2, 0);
    step(0, 1, 0, 0,     32'h8,  32'h22, 32'h8,  1, 2, 0);
    step(0, 1, 0, 0,     32'h8,  32'h22, 32'h8,  1, 2, 0);
    step(0, 0, 0, 0,     32'hC,  32'h33, 32'hC,  1, 3, 0);
    step(0, 0, 0, 0,     32'h10, 32'h44, 32'h10, 1, 4, 0);
    // misaligned redirect from pc=0x10
    step(0, 0, 1, 32'h23, 32'h20, 32'h0,    32'h10, 0, 4, 0);
    step(0, 0, 0, 0,      32'h24, 32'h1008, 32'h24, 1, 5, 0);
    // redirect with stall: redirect wins
    step(0, 1, 1, 32'h4,  32'h4,  32'h0,    32'h24, 0, 5, 0);
    step(0, 0, 0, 0,      32'h8,  32'h22,   32'h8,  1, 6, 0);
    // reset overrides stall and redirect
    step(1, 1, 1, 32'h40, 32'h0,  32'h0,    32'h0,  0, 0, 0);
    step(0, 0, 0, 0,      32'h4,  32'h11,   32'h4,  1, 1, 0);

`ifdef IMEM_RANGE_CHECK_EN
    for (int i = 1; i < 64; i++) begin
      step(0, 0, 0, 0, 32'(4 * (i + 1)), rom_word(32'(i)), 32'(4 * (i + 1)), 1, 32'(i + 1), 0);
    end
    // pc=0x100 is past the 64-word ROM
    step(0, 0, 0, 0,     32'h104, 32'h0, 32'h104, 0, 64, 1);
    step(0, 0, 1, 32'h0, 32'h0,   32'h0, 32'h104, 0, 64, 1);
    step(0, 0, 0, 0,     32'h4,   32'h11, 32'h4,  1, 65, 1);
`else
    // PC wrap at the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0, 32'h4, 0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1, 2, 0);
    step(0, 0, 0, 0, 32'h4, 32'h11,        32'h4, 1, 3, 0);
`endif

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue MIPS pipeline. Holds the program counter, drives the word address into the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It also handles decode-stage stalls and branch/jump redirects. It sits directly upstream of the instruction ROM and feeds the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; must be word-aligned.
- IMEM_WORDS, 64, instruction ROM depth in words; used only when range checking is compiled in.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- stall  in  1  decode-stage hazard; hold PC and IF/ID.
- redirect  in  1  taken branch or jump resolved in decode.
- redirect_pc  in  32  byte target address for redirect.
- imem_addr  out  32  word index to ROM, i.e. {2'b00, pc[31:2]}; combinational from pc.
- imem_rdata  in  32  instruction word from ROM, combinational on imem_addr.
- pc  out  32  current fetch byte address.
- if_id_instr  out  32  registered instruction for decode.
- if_id_pc4  out  32  registered pc+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  out  32  number of instructions accepted into IF/ID.
- fetch_fault  out  1  sticky out-of-range flag; constant 0 unless IMEM_RANGE_CHECK_EN.

## Operation
- Next-PC priority, evaluated each rising edge: reset > redirect > stall > sequential.
  - reset: pc <= RESET_PC; if_id_instr <= 0; if_id_pc4 <= 0; if_id_valid <= 0; fetch_count <= 0; fetch_fault <= 0.
  - redirect (takes precedence over simultaneous stall): pc <= {redirect_pc[31:2], 2'b00}. IF/ID is flushed: if_id_instr <= 0 (NOP), if_id_valid <= 0, if_id_pc4 unchanged. fetch_count unchanged.
  - stall (no redirect): pc, IF/ID and fetch_count hold.
  - sequential: pc <= pc + 4. IF/ID captures if_id_instr <= imem_rdata, if_id_pc4 <= pc + 4, if_id_valid <= 1. fetch_count increments.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 without a fault.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- Misaligned redirect_pc: low two bits are silently cleared. No exception is raised.

## Timing
- Fetch latency is one cycle. The ROM read is combinational in the same cycle as pc, and the instruction appears on if_id_instr after the next rising edge.
- First instruction: at the first edge with reset low, IF/ID captures ROM[RESET_PC>>2], if_id_valid becomes 1, and pc becomes RESET_PC+4.
- Redirect penalty is exactly one bubble. The cycle after redirect shows if_id_valid=0, and the target instruction appears one cycle later.
- stall may be held for any number of cycles. Outputs are bit-stable throughout, and the instruction at pc is fetched on the first non-stalled edge.
- Reset asserted mid-stream overrides stall and redirect in the same cycle.

## Configuration
- IMEM_RANGE_CHECK_EN
  - Defined: when pc[31:2] >= IMEM_WORDS on a sequential edge, IF/ID captures NOP (32'h0) with if_id_valid=0 instead of imem_rdata. fetch_fault sets and stays set until reset, fetch_count does not increment, and pc still advances.
  - Undefined: no check; imem_rdata is captured as-is, and fetch_fault is tied to 0.

## Structure
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0000_0000
  - PC_STEP = 4
  - a typedef for the 32-bit word
- Natural sub-module: if_id_reg, holding the IF/ID register with load/hold/flush controls and the valid bit. fetch_stage keeps the PC, next-PC mux, counter and fault logic.

## Test plan
- Reset then run with ROM[0..3] = 11,22,33,44 (hex words): if_id_instr shows 0x11, 0x22, 0x33 on successive cycles; if_id_pc4 shows 4, 8, 12; fetch_count=3.
- Stall for 3 cycles while pc=8: pc, if_id_instr and fetch_count are unchanged for those 3 cycles, and ROM[2] is captured on release.
- Redirect with redirect_pc=0x23 while pc=0x10: next cycle pc=0x20, if_id_valid=0, if_id_instr=0; cycle after, if_id_instr=ROM[8].
- Redirect and stall asserted together: redirect wins, with pc equal to the target and IF/ID flushed.
- Reset asserted mid-stream with stall=1 and redirect=1: pc=RESET_PC, if_id_valid=0, fetch_count=0.
- With IMEM_RANGE_CHECK_EN and IMEM_WORDS=64, run sequentially to pc=0x100: fetch_fault=1, if_id_valid=0, fetch_count frozen at 64, and fetch_fault remains 1 after a subsequent redirect to 0.
